// File: rtl/axis_pkt_fifo_pkg.sv
// Shared types and pointer-width helpers for the AXI-Stream packet FIFO.
package axis_pkt_fifo_pkg;

    typedef enum logic [0:0] {
        ST_ACCEPT = 1'b0,
        ST_DROP   = 1'b1
    } wr_state_t;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    function automatic int ptr_bits(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int addr_bits(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/axis_pkt_fifo_ram.sv
// Simple dual-port storage with a registered read port; contents are not reset.
module axis_pkt_fifo_ram
    import axis_pkt_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = addr_bits(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/axis_pkt_fifo.sv
// AXI-Stream packet FIFO: store-and-forward with bad/oversize frame drop, or cut-through.
module axis_pkt_fifo
    import axis_pkt_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 64,
    parameter int STORE_FWD  = 1,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_WIDTH-1:0]     s_tdata,
    input  logic [DATA_WIDTH/8-1:0]   s_tkeep,
    input  logic                      s_tlast,
    input  logic                      s_tuser,
    input  logic                      s_tvalid,
    output logic                      s_tready,
    output logic [DATA_WIDTH-1:0]     m_tdata,
    output logic [DATA_WIDTH/8-1:0]   m_tkeep,
    output logic                      m_tlast,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic [CNT_WIDTH-1:0]      pkt_in_cnt,
    output logic [CNT_WIDTH-1:0]      pkt_out_cnt,
    output logic [CNT_WIDTH-1:0]      drop_cnt,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int KW = DATA_WIDTH / 8;
    localparam int PW = ptr_bits(DEPTH);
    localparam int AW = addr_bits(DEPTH);
    localparam int EW = DATA_WIDTH + KW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] ONE_P   = PW'(1);
    localparam logic [CNT_WIDTH-1:0] ONE_C = CNT_WIDTH'(1);

    // Handshake: a beat moves on a side only at a rising edge where valid and ready are both high.
    wr_state_t     state, state_nx;
    logic [PW-1:0] wr, cm, rd;
    logic [PW-1:0] wr_nx, cm_nx, rd_nx;
    logic          rdy_en;
    logic          full, empty;
    logic          s_fire, m_fire, rd_en, wr_en, ovf;
    logic          out_vld;
    logic          pkt_in_inc, drop_inc;
    logic [EW-1:0] rdata;

    assign full   = ((wr - rd) == DEPTH_P);
    assign empty  = (cm == rd);
    assign s_fire = s_tvalid && s_tready;
    assign m_fire = out_vld && m_tready;
    assign rd_en  = !empty && (!out_vld || m_tready);

    // Oversize: this beat would fill the store while nothing committed is ahead of it.
    assign ovf = (STORE_FWD != 0) && (state == ST_ACCEPT) && s_fire && !s_tlast &&
                 (rd == cm) && ((wr + ONE_P - rd) == DEPTH_P);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_ACCEPT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_ACCEPT: if (ovf) state_nx = ST_DROP;
            ST_DROP:   if (s_fire && s_tlast) state_nx = ST_ACCEPT;
            default:   state_nx = ST_ACCEPT;
        endcase
    end

    always_comb begin
        s_tready = rdy_en && ((state == ST_DROP) || !full);
        wr_en    = s_fire && (state == ST_ACCEPT) && !ovf;
    end

    always_comb begin
        wr_nx      = wr;
        cm_nx      = cm;
        rd_nx      = rd_en ? (rd + ONE_P) : rd;
        pkt_in_inc = 1'b0;
        drop_inc   = 1'b0;
        if (s_fire && (state == ST_ACCEPT)) begin
            if (STORE_FWD == 0) begin
                wr_nx      = wr + ONE_P;
                cm_nx      = wr + ONE_P;
                pkt_in_inc = s_tlast;
            end else if (ovf) begin
                wr_nx = cm;
            end else if (s_tlast && s_tuser) begin
                wr_nx    = cm;
                drop_inc = 1'b1;
            end else if (s_tlast) begin
                wr_nx      = wr + ONE_P;
                cm_nx      = wr + ONE_P;
                pkt_in_inc = 1'b1;
            end else begin
                wr_nx = wr + ONE_P;
            end
        end
        if (s_fire && (state == ST_DROP) && s_tlast) begin
            drop_inc = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr          <= '0;
            cm          <= '0;
            rd          <= '0;
            rdy_en      <= 1'b0;
            out_vld     <= 1'b0;
            level       <= '0;
            pkt_in_cnt  <= '0;
            pkt_out_cnt <= '0;
            drop_cnt    <= '0;
        end else begin
            wr     <= wr_nx;
            cm     <= cm_nx;
            rd     <= rd_nx;
            rdy_en <= 1'b1;
            level  <= wr_nx - rd_nx;
            if (rd_en) begin
                out_vld <= 1'b1;
            end else if (m_fire) begin
                out_vld <= 1'b0;
            end
            if (pkt_in_inc) pkt_in_cnt <= pkt_in_cnt + ONE_C;
            if (drop_inc) drop_cnt <= drop_cnt + ONE_C;
            if (m_fire && m_tlast) pkt_out_cnt <= pkt_out_cnt + ONE_C;
        end
    end

    axis_pkt_fifo_ram #(
        .WIDTH (EW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr[AW-1:0]),
        .wdata ({s_tdata, s_tkeep, s_tlast}),
        .re    (rd_en),
        .raddr (rd[AW-1:0]),
        .rdata (rdata)
    );

    // The RAM read register is the egress stage; gating keeps outputs clean when idle or in reset.
    assign m_tvalid = out_vld;
    assign {m_tdata, m_tkeep, m_tlast} = out_vld ? rdata : '0;

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Bench for axis_pkt_fifo: three configurations share one stimulus bus, selected by sel.
module tb_axis_pkt_fifo;

    localparam int EW = 128 + 16 + 1;

    logic         clk;
    logic         rst_n;
    logic [127:0] s_tdata;
    logic [15:0]  s_tkeep;
    logic         s_tlast, s_tuser, s_tvalid;
    logic         m_tready;
    int           sel;

    logic         st_rdy [3];
    logic         mv     [3];
    logic [127:0] md     [3];
    logic [15:0]  mk     [3];
    logic         ml     [3];
    logic [7:0]   pin    [3];
    logic [7:0]   pout   [3];
    logic [7:0]   pdrop  [3];
    logic [6:0]   lvl_sf, lvl_ct;
    logic [3:0]   lvl_sm;

    logic         c_tready, c_mvalid, c_mlast;
    logic [127:0] c_mdata;
    logic [15:0]  c_mkeep;
    logic [7:0]   c_pin, c_pout, c_drop;
    logic [6:0]   c_level;

    logic [EW-1:0] exp_q[$];
    int n_vec, n_err, n_pop, cyc;
    bit first_seen;
    int first_cyc;
    bit hold_pend;
    logic [EW:0] hold_val;
    bit drv_done;

    axis_pkt_fifo #(.DATA_WIDTH(128), .DEPTH(64), .STORE_FWD(1), .CNT_WIDTH(8)) u_sf (
        .clk(clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .s_tuser(s_tuser), .s_tvalid(s_tvalid && (sel == 0)), .s_tready(st_rdy[0]),
        .m_tdata(md[0]), .m_tkeep(mk[0]), .m_tlast(ml[0]), .m_tvalid(mv[0]), .m_tready(m_tready),
        .pkt_in_cnt(pin[0]), .pkt_out_cnt(pout[0]), .drop_cnt(pdrop[0]), .level(lvl_sf));

    axis_pkt_fifo #(.DATA_WIDTH(128), .DEPTH(8), .STORE_FWD(1), .CNT_WIDTH(8)) u_sm (
        .clk(clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .s_tuser(s_tuser), .s_tvalid(s_tvalid && (sel == 1)), .s_tready(st_rdy[1]),
        .m_tdata(md[1]), .m_tkeep(mk[1]), .m_tlast(ml[1]), .m_tvalid(mv[1]), .m_tready(m_tready),
        .pkt_in_cnt(pin[1]), .pkt_out_cnt(pout[1]), .drop_cnt(pdrop[1]), .level(lvl_sm));

    axis_pkt_fifo #(.DATA_WIDTH(128), .DEPTH(64), .STORE_FWD(0), .CNT_WIDTH(8)) u_ct (
        .clk(clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .s_tuser(s_tuser), .s_tvalid(s_tvalid && (sel == 2)), .s_tready(st_rdy[2]),
        .m_tdata(md[2]), .m_tkeep(mk[2]), .m_tlast(ml[2]), .m_tvalid(mv[2]), .m_tready(m_tready),
        .pkt_in_cnt(pin[2]), .pkt_out_cnt(pout[2]), .drop_cnt(pdrop[2]), .level(lvl_ct));

    assign c_tready = st_rdy[sel];
    assign c_mvalid = mv[sel];
    assign c_mdata  = md[sel];
    assign c_mkeep  = mk[sel];
    assign c_mlast  = ml[sel];
    assign c_pin    = pin[sel];
    assign c_pout   = pout[sel];
    assign c_drop   = pdrop[sel];
    assign c_level  = (sel == 1) ? {3'b000, lvl_sm} : ((sel == 2) ? lvl_ct : lvl_sf);

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic send_beat(input logic [127:0] d, input logic [15:0] k, input logic l,
                             input logic u, output int acc, output int stalls);
        int  w;
        bit  done;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tuser  = u;
        s_tvalid = 1'b1;
        done = 0;
        w = 0;
        stalls = 0;
        acc = -1;
        while (!done && w < 400) begin
            @(negedge clk);
            if (c_tready) begin
                acc  = cyc;
                done = 1;
            end else begin
                stalls++;
            end
            step();
            w++;
        end
        n_vec++;
        assert (done) else begin
            n_err++;
            $error("FAIL beat_timeout obs=%0d exp=accepted", w);
        end
    endtask

    task automatic send_pkt(input int len, input bit user, input bit good,
                            output int first_acc, output int last_acc, output int stalls);
        logic [127:0] d;
        logic [15:0]  k;
        logic         l;
        int           a, s;
        stalls = 0;
        first_acc = -1;
        last_acc = -1;
        for (int i = 0; i < len; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            l = (i == len - 1);
            k = l ? (16'($urandom) | 16'h0001) : 16'hffff;
            if (good) exp_q.push_back({d, k, l});
            send_beat(d, k, l, user && l, a, s);
            if (i == 0) first_acc = a;
            last_acc = a;
            stalls += s;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
    endtask

    task automatic send_burst(input int npkt, input int len);
        int a, b, s;
        for (int p = 0; p < npkt; p++) send_pkt(len, 1'b0, 1'b1, a, b, s);
        drv_done = 1;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || c_mvalid) && w < 1000) begin
            step();
            w++;
        end
        n_vec++;
        assert (exp_q.size() == 0) else begin
            n_err++;
            $error("FAIL drain_timeout obs=%0d exp=0", exp_q.size());
        end
        repeat (3) step();
    endtask

    // scoreboard: egress beats are popped from exp_q; stalled beats must hold
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rst_n) begin
            if (c_mvalid && !first_seen) begin
                first_seen = 1;
                first_cyc  = cyc;
            end
            if (hold_pend) chk("egress_hold", {c_mvalid, c_mdata, c_mkeep, c_mlast}, hold_val);
            if (c_mvalid && m_tready) begin
                n_pop++;
                n_vec++;
                assert (exp_q.size() != 0) else begin
                    n_err++;
                    $error("FAIL egress_extra obs=%0h exp=none", {c_mdata, c_mkeep, c_mlast});
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("egress_beat", {c_mdata, c_mkeep, c_mlast}, e);
                end
            end
            hold_pend = c_mvalid && !m_tready;
            hold_val  = {c_mvalid, c_mdata, c_mkeep, c_mlast};
        end else begin
            hold_pend = 0;
        end
    end

    initial begin
        int fa, la, st, pops0;
        cyc = 0; n_vec = 0; n_err = 0; n_pop = 0;
        first_seen = 0; first_cyc = -1; hold_pend = 0; drv_done = 0;
        rst_n = 1'b0; sel = 0; m_tready = 1'b1;
        s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tuser = 1'b0; s_tvalid = 1'b0;

        // reset state
        repeat (3) step();
        @(negedge clk);
        chk("rst_s_tready", c_tready, 0);
        chk("rst_m_tvalid", c_mvalid, 0);
        chk("rst_m_tdata", c_mdata, 0);
        chk("rst_level", c_level, 0);
        chk("rst_counters", {c_pin, c_pout, c_drop}, 0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("deassert_s_tready_low", c_tready, 0);
        step();
        @(negedge clk);
        chk("deassert_s_tready_high", c_tready, 1);
        step();

        // three good 4-beat packets, store-and-forward
        first_seen = 0;
        pops0 = n_pop;
        send_pkt(4, 0, 1, fa, la, st);
        send_pkt(4, 0, 1, fa, st, st);
        send_pkt(4, 0, 1, fa, st, st);
        wait_drain();
        chk("sf_latency", first_cyc, la + 2);
        chk("sf_pops", n_pop - pops0, 12);
        chk("sf_pkt_in", c_pin, 3);
        chk("sf_pkt_out", c_pout, 3);
        chk("sf_level", c_level, 0);

        // bad frame dropped, good frame follows
        pops0 = n_pop;
        send_pkt(5, 1, 0, fa, la, st);
        @(negedge clk);
        chk("bad_level_rollback", c_level, 0);
        step();
        send_pkt(2, 0, 1, fa, la, st);
        wait_drain();
        chk("bad_pops", n_pop - pops0, 2);
        chk("bad_drop_cnt", c_drop, 1);
        chk("bad_pkt_in", c_pin, 4);
        chk("bad_level", c_level, 0);

        // oversize packet on the 8-entry instance
        sel = 1;
        step();
        pops0 = n_pop;
        send_pkt(12, 0, 0, fa, la, st);
        repeat (6) step();
        chk("ovs_stalls", st, 0);
        chk("ovs_no_egress", n_pop - pops0, 0);
        chk("ovs_drop_cnt", c_drop, 1);
        chk("ovs_pkt_in", c_pin, 0);
        send_pkt(3, 0, 1, fa, la, st);
        wait_drain();
        chk("ovs_next_pops", n_pop - pops0, 3);
        chk("ovs_next_pkt_out", c_pout, 1);
        chk("ovs_level", c_level, 0);

        // cut-through ignores tuser
        sel = 2;
        step();
        first_seen = 0;
        pops0 = n_pop;
        send_pkt(4, 1, 1, fa, la, st);
        wait_drain();
        chk("ct_latency", first_cyc, fa + 2);
        chk("ct_pops", n_pop - pops0, 4);
        chk("ct_drop_cnt", c_drop, 0);
        chk("ct_pkt_in", c_pin, 1);
        chk("ct_pkt_out", c_pout, 1);

        // back-pressure fills the store, then drains in order
        sel = 0;
        m_tready = 1'b0;
        step();
        pops0 = n_pop;
        drv_done = 0;
        fork
            send_burst(9, 8);
        join_none
        repeat (70) step();
        @(negedge clk);
        chk("bp_level", c_level, 64);
        chk("bp_s_tready", c_tready, 0);
        chk("bp_m_tvalid", c_mvalid, 1);
        chk("bp_m_front", {c_mdata, c_mkeep, c_mlast}, exp_q[0]);
        step();
        m_tready = 1'b1;
        for (int w = 0; w < 500 && !drv_done; w++) step();
        chk("bp_driver_done", drv_done, 1);
        wait_drain();
        chk("bp_pops", n_pop - pops0, 72);
        chk("bp_pkt_out", c_pout, 13);
        chk("bp_level_end", c_level, 0);

        // reset in the middle of a packet
        m_tready = 1'b0;
        send_pkt(4, 0, 1, fa, la, st);
        for (int i = 0; i < 3; i++) send_beat({4{$urandom}}, 16'hffff, 1'b0, 1'b0, fa, st);
        s_tvalid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_m_tvalid", c_mvalid, 0);
        chk("mid_rst_m_tdata", c_mdata, 0);
        chk("mid_rst_counters", {c_pin, c_pout, c_drop}, 0);
        chk("mid_rst_level", c_level, 0);
        chk("mid_rst_s_tready", c_tready, 0);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        step();
        @(negedge clk);
        chk("mid_rst_s_tready_rise", c_tready, 1);
        step();
        m_tready = 1'b1;
        pops0 = n_pop;
        send_pkt(6, 0, 1, fa, la, st);
        wait_drain();
        chk("mid_rst_pops", n_pop - pops0, 6);
        chk("mid_rst_pkt_in", c_pin, 1);
        chk("mid_rst_pkt_out", c_pout, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
